// File: rtl/lms_ctr_spi_pkg.sv
// Shared definitions for the LMS-style SPI slave: register map, status/control
// bit positions and the serial engine state encoding.
package lms_ctr_spi_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int BIT_ROE  = 3;
  localparam int BIT_TOE  = 4;
  localparam int BIT_TMT  = 5;
  localparam int BIT_TRDY = 6;
  localparam int BIT_RRDY = 7;
  localparam int BIT_E    = 8;

  // Only the interrupt-enable bits of control are implemented.
  localparam logic [15:0] CTRL_MASK = 16'h01D8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

  function automatic logic [15:0] pack_status(input logic roe, input logic toe,
                                              input logic tmt, input logic trdy,
                                              input logic rrdy);
    logic [15:0] s;
    s           = 16'h0000;
    s[BIT_ROE]  = roe;
    s[BIT_TOE]  = toe;
    s[BIT_TMT]  = tmt;
    s[BIT_TRDY] = trdy;
    s[BIT_RRDY] = rrdy;
    s[BIT_E]    = roe | toe;
    return s;
  endfunction

endpackage

// File: rtl/lms_ctr_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with edge detect taken
// from the last two stages.
module lms_ctr_spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] ff;

  // Shift chain; bit 0 is the newest sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], din};
    end
  end

  assign lvl  = ff[STAGES-1];
  assign rise = ff[STAGES-2] & ~ff[STAGES-1];
  assign fall = ~ff[STAGES-2] & ff[STAGES-1];

endmodule

// File: rtl/lms_ctr_spi_slave.sv
// SPI slave (CPOL=0, CPHA=0) with an Avalon-like register port: rxdata, txdata,
// status and control, plus a registered interrupt.
module lms_ctr_spi_slave
  import lms_ctr_spi_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int BW = $clog2(DATABITS + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  lms_ctr_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SCLK),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  lms_ctr_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(SS_n),
    .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall));
  lms_ctr_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MOSI),
    .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  spi_state_t          state, state_next;
  logic [FW-1:0]       flush_cnt;
  logic                armed;
  logic [BW-1:0]       bitcnt;
  logic [DATABITS-1:0] rx_shift, rx_holding, tx_shift, tx_holding, rx_next;
  logic                rrdy, roe, toe, trdy;
  logic [15:0]         control, rd_data, wr_data;
  logic [2:0]          wr_addr;
  logic                taken, wr_pend;
  logic                strobe, rd_take, wr_take, tx_wr, st_wr, ctl_wr, rx_rd;
  logic                load_evt, rise_evt, fall_evt, byte_done;

  // SS_n must be seen high after the synchronizer has flushed before a frame
  // may start, so a low SS_n across reset never launches a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= {FW{1'b0}};
      armed     <= 1'b0;
    end else if (flush_cnt != FW'(SYNC_STAGES)) begin
      flush_cnt <= flush_cnt + FW'(1);
    end else if (ss_lvl) begin
      armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an SS_n rise aborts from any state.
  always_comb begin
    state_next = state;
    if (ss_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = (ss_fall && armed) ? ST_LOAD : ST_IDLE;
        ST_LOAD:  state_next = ST_SHIFT;
        ST_SHIFT: state_next = ST_SHIFT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  assign rise_evt  = (state == ST_SHIFT) && sclk_rise && !ss_rise;
  assign fall_evt  = (state == ST_SHIFT) && sclk_fall && !ss_rise;
  assign load_evt  = !ss_rise && ((state == ST_LOAD) || (fall_evt && (bitcnt == BW'(DATABITS))));
  assign byte_done = rise_evt && (bitcnt == BW'(DATABITS - 1));
  assign rx_next   = {rx_shift[DATABITS-2:0], mosi_lvl};

  assign strobe  = spi_select && (!read_n || !write_n) && !taken;
  assign rd_take = strobe && !read_n;
  assign wr_take = strobe && !write_n;
  assign rx_rd   = rd_take && (mem_addr == ADDR_RXDATA);
  assign tx_wr   = wr_pend && (wr_addr == ADDR_TXDATA);
  assign st_wr   = wr_pend && (wr_addr == ADDR_STATUS);
  assign ctl_wr  = wr_pend && (wr_addr == ADDR_CONTROL);

  // Read mux, sampled into data_to_cpu when a read strobe is taken.
  always_comb begin
    rd_data = 16'h0000;
    case (mem_addr)
      ADDR_RXDATA:  rd_data = {{(16-DATABITS){1'b0}}, rx_holding};
      ADDR_STATUS:  rd_data = pack_status(roe, toe, trdy && (state == ST_IDLE), trdy, rrdy);
      ADDR_CONTROL: rd_data = control;
      default:      rd_data = 16'h0000;
    endcase
  end

  // Serial datapath and CPU-visible state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt      <= {BW{1'b0}};
      rx_shift    <= {DATABITS{1'b0}};
      rx_holding  <= {DATABITS{1'b0}};
      tx_shift    <= {DATABITS{1'b0}};
      tx_holding  <= {DATABITS{1'b0}};
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      trdy        <= 1'b1;
      control     <= 16'h0000;
      taken       <= 1'b0;
      wr_pend     <= 1'b0;
      wr_addr     <= 3'd0;
      wr_data     <= 16'h0000;
      data_to_cpu <= 16'h0000;
      irq         <= 1'b0;
    end else begin
      taken   <= strobe;
      wr_pend <= wr_take;
      if (wr_take) begin
        wr_addr <= mem_addr;
        wr_data <= data_from_cpu;
      end
      if (rd_take) begin
        data_to_cpu <= rd_data;
      end

      if (load_evt) begin
        tx_shift <= trdy ? {DATABITS{1'b0}} : tx_holding;
        bitcnt   <= {BW{1'b0}};
      end else begin
        if (fall_evt) begin
          tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};
        end
        if (rise_evt) begin
          bitcnt <= bitcnt + BW'(1);
        end
      end
      if (rise_evt) begin
        rx_shift <= rx_next;
      end
      if (byte_done) begin
        rx_holding <= rx_next;
      end

      // A txdata write is judged against TRDY as it stood before any load this cycle.
      if (tx_wr && trdy) begin
        tx_holding <= wr_data[DATABITS-1:0];
        trdy       <= 1'b0;
      end else if (load_evt && !trdy) begin
        trdy <= 1'b1;
      end

      if (byte_done) begin
        rrdy <= 1'b1;
      end else if (rx_rd || st_wr) begin
        rrdy <= 1'b0;
      end
      if (byte_done && rrdy) begin
        roe <= 1'b1;
      end else if (st_wr) begin
        roe <= 1'b0;
      end
      if (tx_wr && !trdy) begin
        toe <= 1'b1;
      end else if (st_wr) begin
        toe <= 1'b0;
      end
      if (ctl_wr) begin
        control <= wr_data & CTRL_MASK;
      end

      irq <= (roe && control[BIT_ROE]) || (toe && control[BIT_TOE]) ||
             (trdy && control[BIT_TRDY]) || (rrdy && control[BIT_RRDY]) ||
             ((roe || toe) && control[BIT_E]);
    end
  end

  assign MISO          = tx_shift[DATABITS-1];
  assign MISO_oe       = ~ss_lvl;
  assign dataavailable = rrdy;
  assign readyfordata  = trdy;

endmodule

// File: tb/tb_lms_ctr_spi_slave.sv
// Directed self-checking bench for lms_ctr_spi_slave: register map, single and
// back-to-back frames, overruns, aborted frames, interrupt timing and reset.
module tb_lms_ctr_spi_slave;

  logic        clk = 1'b0;
  logic        reset, SCLK, SS_n, MOSI, MISO, MISO_oe;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        read_n, write_n, spi_select, irq, dataavailable, readyfordata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lms_ctr_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .read_n(read_n), .write_n(write_n),
    .spi_select(spi_select), .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata));

  always #5 clk = ~clk;

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
    wclk(1);
    write_n = 1'b1; spi_select = 1'b0;
    wclk(1);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
    wclk(1);
    d = data_to_cpu;
    read_n = 1'b1; spi_select = 1'b0;
    wclk(1);
  endtask

  task automatic ss_set(input logic v);
    SS_n = v;
    wclk(6);
  endtask

  // Master side: MOSI set up half a period ahead, MISO captured while SCLK is high.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      wclk(5);
      SCLK = 1'b1;
      wclk(2);
      mi[7-i] = MISO;
      wclk(3);
      SCLK = 1'b0;
    end
    wclk(5);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reset = 1'b1;
    wclk(4);
    total_cnt++; if (MISO !== 1'b0) $display("FAIL rst_miso: got %b want 0", MISO); else pass_cnt++;
    total_cnt++; if (MISO_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", MISO_oe); else pass_cnt++;
    total_cnt++; if (data_to_cpu !== 16'h0000) $display("FAIL rst_dout: got %h want 0000", data_to_cpu); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else pass_cnt++;
    total_cnt++; if (dataavailable !== 1'b0) $display("FAIL rst_rrdy: got %b want 0", dataavailable); else pass_cnt++;
    total_cnt++; if (readyfordata !== 1'b1) $display("FAIL rst_trdy: got %b want 1", readyfordata); else pass_cnt++;
    reset = 1'b0;
    wclk(5);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h0060) $display("FAIL rst_status: got %h want 0060", d); else pass_cnt++;
    cpu_read(3'd3, d);
    total_cnt++; if (d !== 16'h0000) $display("FAIL rst_control: got %h want 0000", d); else pass_cnt++;
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h0000) $display("FAIL rst_rxdata: got %h want 0000", d); else pass_cnt++;
  endtask

  task automatic test_single_byte;
    logic [15:0] d;
    logic [7:0]  mi;
    cpu_write(3'd1, 16'h00A5);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h0000) $display("FAIL primed_status: got %h want 0000", d); else pass_cnt++;
    ss_set(1'b0);
    total_cnt++; if (MISO_oe !== 1'b1) $display("FAIL oe_active: got %b want 1", MISO_oe); else pass_cnt++;
    spi_bits(8'h3C, 8, mi);
    ss_set(1'b1);
    total_cnt++; if (mi !== 8'hA5) $display("FAIL single_miso: got %h want a5", mi); else pass_cnt++;
    total_cnt++; if (MISO_oe !== 1'b0) $display("FAIL oe_idle: got %b want 0", MISO_oe); else pass_cnt++;
    total_cnt++; if (dataavailable !== 1'b1) $display("FAIL single_rrdy: got %b want 1", dataavailable); else pass_cnt++;
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h00E0) $display("FAIL single_status: got %h want 00e0", d); else pass_cnt++;
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h003C) $display("FAIL single_rxdata: got %h want 003c", d); else pass_cnt++;
    total_cnt++; if (dataavailable !== 1'b0) $display("FAIL rxread_clears: got %b want 0", dataavailable); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic [7:0]  mi;
    cpu_write(3'd1, 16'h005A);
    ss_set(1'b0);
    spi_bits(8'h11, 8, mi);
    total_cnt++; if (mi !== 8'h5A) $display("FAIL b2b_miso1: got %h want 5a", mi); else pass_cnt++;
    spi_bits(8'h22, 8, mi);
    total_cnt++; if (mi !== 8'h00) $display("FAIL b2b_miso2: got %h want 00", mi); else pass_cnt++;
    ss_set(1'b1);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h01E8) $display("FAIL b2b_roe_status: got %h want 01e8", d); else pass_cnt++;
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h0022) $display("FAIL b2b_rxdata: got %h want 0022", d); else pass_cnt++;
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h0060) $display("FAIL b2b_cleared: got %h want 0060", d); else pass_cnt++;
    ss_set(1'b0);
    spi_bits(8'h33, 8, mi);
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h0033) $display("FAIL b2b_mid_read: got %h want 0033", d); else pass_cnt++;
    spi_bits(8'h44, 8, mi);
    ss_set(1'b1);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h00E0) $display("FAIL b2b_no_roe: got %h want 00e0", d); else pass_cnt++;
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h0044) $display("FAIL b2b_rxdata2: got %h want 0044", d); else pass_cnt++;
  endtask

  task automatic test_tx_overrun;
    logic [15:0] d;
    logic [7:0]  mi;
    cpu_write(3'd1, 16'h0096);
    cpu_write(3'd1, 16'h0069);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h0110) $display("FAIL toe_status: got %h want 0110", d); else pass_cnt++;
    ss_set(1'b0);
    spi_bits(8'h00, 8, mi);
    ss_set(1'b1);
    total_cnt++; if (mi !== 8'h96) $display("FAIL toe_holding_kept: got %h want 96", mi); else pass_cnt++;
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h01F0) $display("FAIL toe_after_frame: got %h want 01f0", d); else pass_cnt++;
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2, d);
    total_cnt++; if (d !== 16'h0060) $display("FAIL status_write_clear: got %h want 0060", d); else pass_cnt++;
  endtask

  task automatic test_abort;
    logic [15:0] d;
    logic [7:0]  mi;
    ss_set(1'b0);
    spi_bits(8'hFF, 5, mi);
    ss_set(1'b1);
    total_cnt++; if (dataavailable !== 1'b0) $display("FAIL abort_rrdy: got %b want 0", dataavailable); else pass_cnt++;
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h0000) $display("FAIL abort_rx_kept: got %h want 0000", d); else pass_cnt++;
    ss_set(1'b0);
    spi_bits(8'h81, 8, mi);
    ss_set(1'b1);
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h0081) $display("FAIL abort_next_frame: got %h want 0081", d); else pass_cnt++;
  endtask

  task automatic test_irq;
    logic [15:0] d;
    logic [7:0]  mi;
    int          n;
    cpu_write(3'd3, 16'hFFFF);
    cpu_read(3'd3, d);
    total_cnt++; if (d !== 16'h01D8) $display("FAIL control_mask: got %h want 01d8", d); else pass_cnt++;
    cpu_write(3'd7, 16'h0000);
    cpu_read(3'd3, d);
    total_cnt++; if (d !== 16'h01D8) $display("FAIL addr7_ignored: got %h want 01d8", d); else pass_cnt++;
    cpu_write(3'd3, 16'h0080);
    wclk(2);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_quiet: got %b want 0", irq); else pass_cnt++;
    ss_set(1'b0);
    spi_bits(8'hC3, 7, mi);
    MOSI = 1'b1;
    wclk(5);
    SCLK = 1'b1;
    n = 0;
    while (dataavailable !== 1'b1 && n < 10) begin
      wclk(1);
      n++;
    end
    total_cnt++; if (dataavailable !== 1'b1) $display("FAIL irq_rrdy_timeout: got %b want 1", dataavailable); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_same_cycle: got %b want 0", irq); else pass_cnt++;
    wclk(1);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_one_later: got %b want 1", irq); else pass_cnt++;
    wclk(3);
    SCLK = 1'b0;
    wclk(5);
    ss_set(1'b1);
    spi_select = 1'b1; mem_addr = 3'd0; read_n = 1'b0;
    wclk(1);
    read_n = 1'b1; spi_select = 1'b0;
    total_cnt++; if (data_to_cpu !== 16'h00C3) $display("FAIL irq_rxdata: got %h want 00c3", data_to_cpu); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_hold: got %b want 1", irq); else pass_cnt++;
    wclk(1);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_clear_2clk: got %b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [15:0] d;
    logic [7:0]  mi;
    cpu_write(3'd1, 16'h00F0);
    ss_set(1'b0);
    spi_bits(8'hF0, 4, mi);
    reset = 1'b1;
    wclk(3);
    total_cnt++; if (MISO !== 1'b0) $display("FAIL mid_rst_miso: got %b want 0", MISO); else pass_cnt++;
    total_cnt++; if (MISO_oe !== 1'b0) $display("FAIL mid_rst_oe: got %b want 0", MISO_oe); else pass_cnt++;
    total_cnt++; if (data_to_cpu !== 16'h0000) $display("FAIL mid_rst_dout: got %h want 0000", data_to_cpu); else pass_cnt++;
    total_cnt++; if (readyfordata !== 1'b1) $display("FAIL mid_rst_trdy: got %b want 1", readyfordata); else pass_cnt++;
    reset = 1'b0;
    wclk(5);
    spi_bits(8'hAA, 8, mi);
    wclk(3);
    total_cnt++; if (dataavailable !== 1'b0) $display("FAIL no_frame_after_rst: got %b want 0", dataavailable); else pass_cnt++;
    ss_set(1'b1);
    ss_set(1'b0);
    spi_bits(8'h5A, 8, mi);
    ss_set(1'b1);
    total_cnt++; if (dataavailable !== 1'b1) $display("FAIL frame_after_cycle: got %b want 1", dataavailable); else pass_cnt++;
    cpu_read(3'd0, d);
    total_cnt++; if (d !== 16'h005A) $display("FAIL rx_after_cycle: got %h want 005a", d); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
    mem_addr = 3'd0; data_from_cpu = 16'h0000;
    wclk(1);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_tx_overrun();
    test_abort();
    test_irq();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lms_ctr_spi_slave.md
LMS_CTR_SPI_SLAVE -- requirements
Module: lms_ctr_spi_slave

Interface
REQ-001 DATABITS, 8, SPI frame width; all data registers are this wide.
REQ-002 SYNC_STAGES, 2, synchronizer depth on SCLK, SS_n and MOSI.
REQ-003 clk  input  1  system clock, 100 MHz; the only clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SCLK  input  1  SPI clock from the external master; CPOL=0, CPHA=0; asynchronous to clk.
REQ-006 SS_n  input  1  slave select, active low, asynchronous.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 MISO  output  1  serial data out, MSB first.
REQ-009 MISO_oe  output  1  tristate enable; high while synced SS_n is low.
REQ-010 mem_addr  input  3  register address.
REQ-011 data_from_cpu  input  16  register write data.
REQ-012 read_n / write_n  input  1 each  active-low access strobes.
REQ-013 spi_select  input  1  register-port select.
REQ-014 data_to_cpu  output  16  registered read data.
REQ-015 irq / dataavailable / readyfordata  output  1 each  registered interrupt, RRDY, TRDY.

Function
REQ-016 Register map:
  - 0 rxdata, read-only.
  - 1 txdata, write-only.
  - 2 status; any write clears ROE, TOE and RRDY.
  - 3 control, read/write.
  - 4-7 read 0; writes to them are ignored.
REQ-017 Status bits: [3] ROE, [4] TOE, [5] TMT, [6] TRDY, [7] RRDY, [8] E=ROE|TOE; all other bits read 0.
REQ-018 Control bits: [3] iROE, [4] iTOE, [6] iTRDY, [7] iRRDY, [8] iE; all other bits read 0.
REQ-019 Register access is a two-cycle event:
  - A strobe is taken only if no strobe was taken the previous cycle.
  - Writes take effect at the end of the second cycle.
  - data_to_cpu is valid one clk after the access begins.
REQ-020 An rxdata read clears RRDY; if a byte completes in the same cycle, RRDY stays 1.
REQ-021 A txdata write loads tx_holding when TRDY=1 and sets primed; when TRDY=0 it sets TOE and leaves tx_holding unchanged.
REQ-022 TRDY=~primed; TMT=~primed & IDLE.
REQ-023 SCLK, SS_n and MOSI each pass through SYNC_STAGES flops; edges are detected from the last two stages; SCLK frequency shall not exceed clk/5.
REQ-024 FSM states are IDLE, LOAD and SHIFT:
  - IDLE->LOAD on a synced SS_n falling edge.
  - LOAD lasts 1 clk: tx_shift gets tx_holding if primed (primed cleared), else 0x00; bitcnt=0; then ->SHIFT.
REQ-025 In SHIFT, a synced SCLK rising edge shifts MOSI into the LSB of rx_shift and increments bitcnt.
REQ-026 In SHIFT, a synced SCLK falling edge shifts tx_shift left:
  - If bitcnt=8, reload tx_shift as in LOAD and clear bitcnt instead.
  - This supports back-to-back bytes under one SS_n assertion.
REQ-027 On the 8th rising edge:
  - rx_holding gets the completed byte and RRDY<=1.
  - If RRDY was already 1, ROE<=1 and rx_holding is still overwritten.
REQ-028 On a synced SS_n rising edge in any state, the FSM goes to IDLE:
  - The partial byte is discarded; RRDY is unchanged.
  - A consumed tx byte is not restored.
REQ-029 MISO=tx_shift[DATABITS-1]; MISO_oe follows synced SS_n low.
REQ-030 A txdata write in the LOAD cycle is judged against pre-load TRDY.
REQ-031 irq is registered, 1 clk latency: (ROE&iROE)|(TOE&iTOE)|(TRDY&iTRDY)|(RRDY&iRRDY)|(E&iE).

Reset
REQ-032 While reset is high:
  - Outputs: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0.
  - Flags: ROE, TOE, RRDY and primed are 0, so TRDY=1 and TMT=1.
  - Registers: control, rx_holding and tx_holding are 0; FSM in IDLE.
  - Sync flops preset to SS_n=1, SCLK=0.
REQ-033 After reset with SS_n held low, no transfer starts until SS_n rises and falls again.

Structure
REQ-034 Shared package lms_ctr_spi_pkg holds register address constants, status/control bit positions and the FSM state enum.
REQ-035 Sub-module lms_ctr_spi_sync (synchronizer plus rise/fall detect) is instantiated once each for SCLK, SS_n and MOSI.

Verification
REQ-036 Write txdata 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; RRDY=1; TMT=1.
REQ-037 Two bytes with no write before the second -> second MISO byte=0x00; second byte received without ROE only if rxdata was read between bytes, else ROE=1.
REQ-038 Second txdata write while primed -> TOE=1, E=1, tx_holding keeps its first value; status write -> ROE, TOE, RRDY all 0.
REQ-039 SS_n rises after 5 SCLK rises -> RRDY unchanged; next full frame 0x81 -> rxdata=0x81.
REQ-040 control=0x080, byte completes -> irq=1 one clk after RRDY; rxdata read -> irq=0 two clks later.
REQ-041 Reset pulse mid-frame with SS_n low -> outputs at reset values; no RRDY until SS_n is cycled.
